// File: rtl/beta_mc_seq.sv
// Multicycle sequencer for the Beta datapath: steps FETCH/DECODE/EXEC/MEM/WB,
// arbitrates the single memory port, enforces an ack timeout and counts retired instructions.
module beta_mc_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_illegal,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_en,
  output logic             pc_en,
  output logic             alu_out_en,
  output logic             mdr_en,
  output logic             reg_we,
  output logic             retire,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } stateT;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  stateT             curState;
  logic [WAIT_W-1:0] waitCnt;
  logic              memAccess;
  logic              endState;

  assign memAccess = dec_mem_read | dec_mem_write;
  assign state     = curState;

  assign mem_req    = (curState == FETCH) || (curState == MEM);
  assign mem_sel    = (curState == MEM);
  assign mem_we     = (curState == MEM) && dec_mem_write;
  assign alu_out_en = (curState == EXEC);
  assign reg_we     = (curState == WB);
  assign busy       = (curState != IDLE) && (curState != FAULT);
  assign fault      = (curState == FAULT);
  assign ir_en      = (curState == FETCH) && mem_ack;
  assign pc_en      = (curState == FETCH) && mem_ack;
  assign mdr_en     = (curState == MEM) && mem_ack && dec_mem_read;

  // An instruction ends in WB, in EXEC when nothing is written, or on the ack of a store.
  assign retire = (curState == WB)
               || ((curState == EXEC) && !memAccess && !dec_reg_write)
               || ((curState == MEM) && mem_ack && !dec_mem_read);

  assign endState = retire;

  // The wait counter only advances while a request waits; every other cycle clears it,
  // so it is already zero on entry to FETCH or MEM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      curState    <= IDLE;
      waitCnt     <= '0;
      instr_count <= '0;
    end else begin
      waitCnt <= '0;
      if (endState) instr_count <= instr_count + 1'b1;
      case (curState)
        IDLE: begin
          if (run) curState <= FETCH;
        end
        FETCH, MEM: begin
          if (mem_ack) begin
            if (curState == FETCH)  curState <= DECODE;
            else if (dec_mem_read)  curState <= WB;
            else                    curState <= run ? FETCH : IDLE;
          end else if (waitCnt == WAIT_LAST) begin
            curState <= FAULT;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DECODE: begin
          if (dec_illegal || (dec_mem_read && dec_mem_write)) curState <= FAULT;
          else                                                curState <= EXEC;
        end
        EXEC: begin
          if (memAccess)          curState <= MEM;
          else if (dec_reg_write) curState <= WB;
          else                    curState <= run ? FETCH : IDLE;
        end
        WB: begin
          curState <= run ? FETCH : IDLE;
        end
        FAULT: begin
          curState <= FAULT;
        end
        default: begin
          curState <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beta_mc_seq.sv
// Self-checking bench for beta_mc_seq: latency table, hand-written corner sequences,
// and randomized instruction streams compared against a per-instruction trace model.
module tb_beta_mc_seq;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 16;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_FAULT = 6;

  localparam logic [8:0] O_REQ = 9'h100, O_SEL = 9'h080, O_WE  = 9'h040;
  localparam logic [8:0] O_IR  = 9'h020, O_PC  = 9'h010, O_ALU = 9'h008;
  localparam logic [8:0] O_MDR = 9'h004, O_REG = 9'h002, O_RET = 9'h001;

  logic clk = 0;
  logic reset = 0;
  logic run = 0;
  logic dec_reg_write = 0, dec_mem_read = 0, dec_mem_write = 0, dec_illegal = 0;
  logic mem_ack = 0;
  logic mem_req, mem_we, mem_sel, ir_en, pc_en, alu_out_en, mdr_en, reg_we, retire, busy, fault;
  logic [2:0] state;
  logic [CNT_W-1:0] instr_count;
  logic [8:0] dutOuts;

  int checks = 0;
  int failures = 0;
  int modelCnt = 0;

  always #5 clk = ~clk;

  beta_mc_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_illegal(dec_illegal),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_en(ir_en), .pc_en(pc_en), .alu_out_en(alu_out_en), .mdr_en(mdr_en),
    .reg_we(reg_we), .retire(retire), .busy(busy), .fault(fault),
    .state(state), .instr_count(instr_count)
  );

  assign dutOuts = {mem_req, mem_sel, mem_we, ir_en, pc_en, alu_out_en, mdr_en, reg_we, retire};

  typedef struct {
    bit         run;
    bit         ack;
    int         st;
    logic [8:0] outs;
  } cycleT;

  typedef struct {
    string name;
    bit    rw, rd, wr, ill;
    int    md;
    int    expCycles, expReq, expReg;
    bit    expRet, expFault;
  } vecT;

  cycleT expQ[$];
  vecT   vecs[9];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic applyStimulus(input bit r, input bit a);
    run     = r;
    mem_ack = a;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 0;
    applyStimulus(0, 0);
    @(negedge clk);
    reset = 1;
    modelCnt = 0;
  endtask

  task automatic checkIdle(input string tag);
    #1;
    checkOutput({tag, ".state"}, int'(state), S_IDLE);
    checkOutput({tag, ".outs"}, int'(dutOuts), 0);
    checkOutput({tag, ".busyFault"}, int'({busy, fault}), 0);
    checkOutput({tag, ".count"}, int'(instr_count), 0);
  endtask

  task automatic pushCycle(input bit r, input bit a, input int st, input logic [8:0] o);
    cycleT c;
    c.run = r; c.ack = a; c.st = st; c.outs = o;
    expQ.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction, built from the stage rules.
  task automatic genInstr(input bit rw, rd, wr, ill, input int fd, md, input bit runNext,
                          output bit faulted);
    logic [8:0] mo;
    faulted = 0;
    for (int i = 0; i < fd && i < TIMEOUT; i++) pushCycle(rbit(), 0, S_FETCH, O_REQ);
    if (fd >= TIMEOUT) begin faulted = 1; return; end
    pushCycle(rbit(), 1, S_FETCH, O_REQ | O_IR | O_PC);
    pushCycle(rbit(), rbit(), S_DECODE, 0);
    if (ill || (rd && wr)) begin faulted = 1; return; end
    if (!rd && !wr && !rw) begin pushCycle(runNext, rbit(), S_EXEC, O_ALU | O_RET); return; end
    pushCycle(rbit(), rbit(), S_EXEC, O_ALU);
    if (rd || wr) begin
      mo = O_REQ | O_SEL | (wr ? O_WE : 9'h000);
      for (int i = 0; i < md && i < TIMEOUT; i++) pushCycle(rbit(), 0, S_MEM, mo);
      if (md >= TIMEOUT) begin faulted = 1; return; end
      if (rd) pushCycle(rbit(), 1, S_MEM, mo | O_MDR);
      else begin pushCycle(runNext, 1, S_MEM, mo | O_RET); return; end
    end
    pushCycle(runNext, rbit(), S_WB, O_REG | O_RET);
  endtask

  task automatic runTrace(input bit rw, rd, wr, ill, input int tag);
    cycleT c;
    int idx = 0;
    while (expQ.size() > 0) begin
      c = expQ.pop_front();
      @(negedge clk);
      if (idx == 0) begin
        dec_reg_write = rw; dec_mem_read = rd; dec_mem_write = wr; dec_illegal = ill;
      end
      applyStimulus(c.run, c.ack);
      #1;
      checkOutput($sformatf("rnd%0d.%0d.state", tag, idx), int'(state), c.st);
      checkOutput($sformatf("rnd%0d.%0d.outs", tag, idx), int'(dutOuts), int'(c.outs));
      checkOutput($sformatf("rnd%0d.%0d.busyFault", tag, idx), int'({busy, fault}),
                  ((c.st >= S_FETCH && c.st <= S_WB) ? 2 : 0) + (c.st == S_FAULT ? 1 : 0));
      checkOutput($sformatf("rnd%0d.%0d.count", tag, idx), int'(instr_count), modelCnt);
      if ((c.outs & O_RET) != 0) modelCnt = (modelCnt + 1) % CNT_MOD;
      idx++;
    end
  endtask

  // Runs one instruction from IDLE with an immediate fetch ack and a data ack after md waits.
  task automatic runInstr(input bit rw, rd, wr, ill, input int md,
                          output int cycles, output int reqCyc, output int regCyc,
                          output bit retired, output bit faulted);
    cycles = 0; reqCyc = 0; regCyc = 0; retired = 0; faulted = 0;
    @(negedge clk);
    dec_reg_write = rw; dec_mem_read = rd; dec_mem_write = wr; dec_illegal = ill;
    applyStimulus(1, 0);
    @(negedge clk);
    run = 0;
    for (int i = 0; i < 64; i++) begin
      if (state == 3'(S_FAULT)) begin faulted = 1; break; end
      mem_ack = (state == 3'(S_FETCH)) || (state == 3'(S_MEM) && reqCyc == md);
      #1;
      cycles++;
      if (state == 3'(S_MEM) && mem_req) reqCyc++;
      if (reg_we) regCyc++;
      if (retire) begin retired = 1; break; end
      @(negedge clk);
    end
    if (retired) begin
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, req, rg, t, fd, md;
    bit ret, flt, rw, rd, wr, ill, rn;

    vecs[0] = '{"alu",        1, 0, 0, 0, 0,  4, 0, 1, 1, 0};
    vecs[1] = '{"load0",      1, 1, 0, 0, 0,  5, 1, 1, 1, 0};
    vecs[2] = '{"load3",      1, 1, 0, 0, 3,  8, 4, 1, 1, 0};
    vecs[3] = '{"store0",     0, 0, 1, 0, 0,  4, 1, 0, 1, 0};
    vecs[4] = '{"store2",     1, 0, 1, 0, 2,  6, 3, 0, 1, 0};
    vecs[5] = '{"nowrite",    0, 0, 0, 0, 0,  3, 0, 0, 1, 0};
    vecs[6] = '{"illegal",    1, 0, 0, 1, 0,  2, 0, 0, 0, 1};
    vecs[7] = '{"rdwr",       1, 1, 1, 0, 0,  2, 0, 0, 0, 1};
    vecs[8] = '{"memTimeout", 1, 1, 0, 0, 99, 19, 16, 0, 0, 1};

    doReset();
    checkIdle("reset");

    foreach (vecs[i]) begin
      runInstr(vecs[i].rw, vecs[i].rd, vecs[i].wr, vecs[i].ill, vecs[i].md, cyc, req, rg, ret, flt);
      checkOutput({vecs[i].name, ".cycles"}, cyc, vecs[i].expCycles);
      checkOutput({vecs[i].name, ".memReqCycles"}, req, vecs[i].expReq);
      checkOutput({vecs[i].name, ".regWeCycles"}, rg, vecs[i].expReg);
      checkOutput({vecs[i].name, ".retired"}, int'(ret), int'(vecs[i].expRet));
      checkOutput({vecs[i].name, ".faulted"}, int'(flt), int'(vecs[i].expFault));
      if (vecs[i].expRet) modelCnt = (modelCnt + 1) % CNT_MOD;
      #1;
      checkOutput({vecs[i].name, ".count"}, int'(instr_count), modelCnt);
      if (vecs[i].expFault) begin
        doReset();
        checkIdle({vecs[i].name, ".reset"});
      end else begin
        checkOutput({vecs[i].name, ".idleAfter"}, int'(state), S_IDLE);
      end
    end

    // Fetch never acknowledged: exactly TIMEOUT request cycles, then a sticky fault.
    doReset();
    @(negedge clk);
    dec_reg_write = 1; dec_mem_read = 0; dec_mem_write = 0; dec_illegal = 0;
    applyStimulus(1, 0);
    @(negedge clk);
    req = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == 3'(S_FAULT)) break;
      #1;
      if (mem_req) req++;
      @(negedge clk);
    end
    #1;
    checkOutput("fetchTimeout.reqCycles", req, TIMEOUT);
    checkOutput("fetchTimeout.fault", int'(fault), 1);
    checkOutput("fetchTimeout.busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1, 1);
      #1;
      checkOutput($sformatf("faultSticky%0d.state", i), int'(state), S_FAULT);
      checkOutput($sformatf("faultSticky%0d.outs", i), int'(dutOuts), 0);
    end
    doReset();
    checkIdle("faultCleared");

    // Counter wrap with a 4-bit count.
    for (int i = 0; i < 16; i++) begin
      runInstr(1, 0, 0, 0, 0, cyc, req, rg, ret, flt);
      if (i == 7) checkOutput("wrap.mid", int'(instr_count), 8);
    end
    checkOutput("wrap.count", int'(instr_count), 0);

    // Reset asserted while a load waits in MEM.
    runInstr(1, 0, 0, 0, 0, cyc, req, rg, ret, flt);
    checkOutput("preMem.count", int'(instr_count), 1);
    @(negedge clk);
    dec_reg_write = 1; dec_mem_read = 1; dec_mem_write = 0; dec_illegal = 0;
    applyStimulus(1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run = 0;
      mem_ack = (state == 3'(S_FETCH));
      if (state == 3'(S_MEM)) break;
    end
    mem_ack = 0;
    @(negedge clk);
    #1;
    checkOutput("midMem.state", int'(state), S_MEM);
    checkOutput("midMem.memReq", int'(mem_req), 1);
    doReset();
    checkIdle("resetInMem");

    // Randomized instruction stream against the trace model.
    pushCycle(1, 0, S_IDLE, 0);
    for (int n = 0; n < 40; n++) begin
      t = $urandom_range(0, 9);
      rw = (t <= 4) ? 1'b1 : rbit();
      rd = (t == 3 || t == 4 || t == 9);
      wr = (t == 5 || t == 6 || t == 9);
      ill = (t == 8);
      if (t == 7) rw = 0;
      fd = ($urandom_range(0, 14) == 0) ? TIMEOUT : $urandom_range(0, 3);
      md = ($urandom_range(0, 14) == 0) ? TIMEOUT : $urandom_range(0, 3);
      rn = rbit();
      genInstr(rw, rd, wr, ill, fd, md, rn, flt);
      if (flt) begin
        for (int k = 0; k < 3; k++) pushCycle(rbit(), rbit(), S_FAULT, 0);
      end else if (!rn) begin
        pushCycle(1, rbit(), S_IDLE, 0);
      end
      runTrace(rw, rd, wr, ill, n);
      if (flt) begin
        doReset();
        checkIdle($sformatf("rnd%0d.reset", n));
        pushCycle(1, 0, S_IDLE, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
